// File: rtl/vscale_hasti_sram_pkg.sv
// vscale_hasti_sram_pkg: shared HASTI (AHB-Lite) transfer, response and size encodings.
package vscale_hasti_sram_pkg;
   typedef enum logic [1:0] {
      HASTI_TRANS_IDLE,
      HASTI_TRANS_BUSY,
      HASTI_TRANS_NONSEQ,
      HASTI_TRANS_SEQ
   } hasti_trans_t;
   typedef enum logic {
      HASTI_RESP_OKAY,
      HASTI_RESP_ERROR
   } hasti_resp_t;
   typedef enum logic [2:0] {
      HASTI_SIZE_BYTE,
      HASTI_SIZE_HALF,
      HASTI_SIZE_WORD
   } hasti_size_t;
endpackage

// File: rtl/vscale_hasti_wstrb.sv
// vscale_hasti_wstrb: byte-lane write strobe from transfer size and low address bits.
module vscale_hasti_wstrb
   import vscale_hasti_sram_pkg::*;
(
   input  logic [2:0] i_size,
   input  logic [1:0] i_addr,
   output logic [3:0] o_wstrb
);
   always_comb
      o_wstrb = (i_size == HASTI_SIZE_BYTE) ? 4'b0001 << i_addr :
                (i_size == HASTI_SIZE_HALF) ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
endmodule

// File: rtl/vscale_hasti_sram.sv
// vscale_hasti_sram: single-port HASTI SRAM slave with programmable wait states.
// Define VSCALE_HASTI_SRAM_ERR_EN to answer out-of-range/misaligned transfers with a two-cycle ERROR.
module vscale_hasti_sram
   import vscale_hasti_sram_pkg::*;
#(
   parameter int          NWORDS      = 16384,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);
   localparam int AW = $clog2(NWORDS);
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic        r_write;
   logic [2:0]  r_size;
   logic [31:0] r_mem [NWORDS];
   logic        w_done, w_accept, w_illegal, w_we, w_unused;
   logic [31:0] w_off;
   logic [3:0]  w_wstrb;
   logic [AW-1:0] w_idx;
   assign w_done   = r_state == S_DATA && r_cnt == 4'd0;
   assign hready   = r_state == S_IDLE || r_state == S_ERR2 || w_done;
   assign hresp    = (r_state == S_ERR1 || r_state == S_ERR2) ? HASTI_RESP_ERROR : HASTI_RESP_OKAY;
   assign w_accept = hready && hsel && htrans[1];
   assign w_off    = r_addr - BASE_ADDR;
   assign w_idx    = w_off[AW+1:2];
   // a reset landing on the completion edge must not commit the write
   assign w_we     = w_done && r_write && !hreset;
   assign hrdata   = (w_done && !r_write) ? r_mem[w_idx] : 32'd0;
   assign w_unused = ^{hburst, hmastlock, hprot, htrans[0], w_off[31:AW+2], w_off[1:0]};
`ifdef VSCALE_HASTI_SRAM_ERR_EN
   logic [32:0] w_aoff;
   assign w_aoff    = {1'b0, haddr} - {1'b0, BASE_ADDR};
   assign w_illegal = w_aoff[32] || w_aoff[31:0] >= 32'(4 * NWORDS) || hsize > HASTI_SIZE_WORD ||
                      (hsize == HASTI_SIZE_HALF && haddr[0]) ||
                      (hsize == HASTI_SIZE_WORD && haddr[1:0] != 2'd0);
`else
   assign w_illegal = 1'b0;
`endif
   vscale_hasti_wstrb u_wstrb (
      .i_size  (r_size),
      .i_addr  (r_addr[1:0]),
      .o_wstrb (w_wstrb)
   );
   always_comb begin
      w_next = r_state;
      if (r_state == S_ERR1) w_next = S_ERR2;
      else if (hready) w_next = w_accept ? (w_illegal ? S_ERR1 : S_DATA) : S_IDLE;
   end
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept && !w_illegal) r_cnt <= 4'(WAIT_STATES);
         else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      end
   end
   always_ff @(posedge hclk)
      if (w_accept) begin
         r_addr  <= haddr;
         r_write <= hwrite;
         r_size  <= hsize;
      end
   always_ff @(posedge hclk)
      if (w_we)
         for (int i = 0; i < 4; i++)
            if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= hwdata[8*i +: 8];
endmodule

// File: tb/tb_vscale_hasti_sram.sv
// tb_vscale_hasti_sram: table-driven check of a zero-wait instance plus hand sequences on a 3-wait instance.
module tb_vscale_hasti_sram;
   logic        hclk = 1'b0, hreset = 1'b1, hsel0 = 1'b0, hsel3 = 1'b0, hwrite = 1'b0;
   logic [31:0] haddr = 32'd0, hwdata = 32'd0;
   logic [2:0]  hsize = 3'd0, hburst = 3'd0;
   logic [1:0]  htrans = 2'd0;
   logic        hmastlock = 1'b0;
   logic [3:0]  hprot = 4'd0;
   logic [31:0] rdata0, rdata3;
   logic        ready0, ready3, resp0, resp3;
   int checks = 0, failures = 0;
   localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2;
   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_ready;
      logic        e_resp;
      logic [31:0] e_rdata;
   } vec_t;
   vec_t vecs[$];
   always #5 hclk = ~hclk;
   vscale_hasti_sram #(.NWORDS(64), .WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
      .hrdata(rdata0), .hready(ready0), .hresp(resp0));
   vscale_hasti_sram #(.NWORDS(64), .WAIT_STATES(3)) u_dut3 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
      .hrdata(rdata3), .hready(ready3), .hresp(resp3));
   task automatic add(input logic sel, input logic [1:0] t, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input logic er, input logic es,
                      input logic [31:0] ed);
      vec_t v;
      v.sel = sel; v.trans = t; v.wr = w; v.size = sz; v.addr = a; v.wdata = d;
      v.e_ready = er; v.e_resp = es; v.e_rdata = ed;
      vecs.push_back(v);
   endtask
   task automatic drive(input logic s0, input logic s3, input logic [1:0] t, input logic w,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      hsel0 = s0; hsel3 = s3; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = d;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge hclk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 5; i++) add(1, I, 0, 2, 0, 0, 1, 0, 0);
      add(1, N, 1, 2, 32'h00, 32'h0, 1, 0, 0);
      add(1, N, 1, 2, 32'h10, 32'h0BADF00D, 1, 0, 0);
      add(1, N, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 0);
      add(1, N, 1, 2, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF);
      add(1, N, 1, 0, 32'h11, 32'h0, 1, 0, 0);
      add(1, N, 1, 1, 32'h12, 32'h0000AA00, 1, 0, 0);
      add(1, N, 0, 2, 32'h10, 32'h12340000, 1, 0, 0);
      add(1, B, 0, 2, 32'h10, 32'h0, 1, 0, 32'h1234AA00);
      add(0, N, 1, 2, 32'h10, 32'h0, 1, 0, 0);
      add(1, N, 0, 2, 32'h10, 32'hFFFFFFFF, 1, 0, 0);
      add(1, N, 0, 2, 32'h02, 32'h0, 1, 0, 32'h1234AA00);
`ifdef VSCALE_HASTI_SRAM_ERR_EN
      add(1, I, 0, 2, 0, 0, 0, 1, 0);
      add(1, N, 0, 2, 32'h100, 0, 1, 1, 0);
      add(1, I, 0, 2, 0, 0, 0, 1, 0);
      add(1, I, 0, 2, 0, 0, 1, 1, 0);
`else
      add(1, I, 0, 2, 0, 0, 1, 0, 32'h0BADF00D);
      add(1, N, 0, 2, 32'h100, 0, 1, 0, 0);
      add(1, I, 0, 2, 0, 0, 1, 0, 32'h0BADF00D);
      add(1, I, 0, 2, 0, 0, 1, 0, 0);
`endif
      add(1, N, 0, 2, 32'h00, 0, 1, 0, 0);
      add(1, I, 0, 2, 0, 0, 1, 0, 32'h0BADF00D);
      add(1, N, 1, 2, 32'h01, 0, 1, 0, 0);
`ifdef VSCALE_HASTI_SRAM_ERR_EN
      add(1, I, 0, 2, 0, 32'hFFFFFFFF, 0, 1, 0);
      add(1, I, 0, 2, 0, 32'hFFFFFFFF, 1, 1, 0);
      add(1, N, 0, 2, 32'h00, 0, 1, 0, 0);
      add(1, I, 0, 2, 0, 0, 1, 0, 32'h0BADF00D);
`else
      add(1, I, 0, 2, 0, 32'hFFFFFFFF, 1, 0, 0);
      add(1, I, 0, 2, 0, 32'hFFFFFFFF, 1, 0, 0);
      add(1, N, 0, 2, 32'h00, 0, 1, 0, 0);
      add(1, I, 0, 2, 0, 0, 1, 0, 32'hFFFFFFFF);
`endif
      tick;
      tick;
      hreset = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i].sel, 0, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         #4;
         chk($sformatf("v%0d hready", i), {31'b0, ready0}, {31'b0, vecs[i].e_ready});
         chk($sformatf("v%0d hresp", i), {31'b0, resp0}, {31'b0, vecs[i].e_resp});
         chk($sformatf("v%0d hrdata", i), rdata0, vecs[i].e_rdata);
         tick;
      end
      // three-wait write with the next read held on the bus until hready rises
      drive(0, 1, N, 1, 2, 32'h20, 0);
      #4 chk("ws3 idle hready", {31'b0, ready3}, 32'd1);
      tick;
      drive(0, 1, N, 0, 2, 32'h20, 32'h5A5A1234);
      for (int c = 0; c < 3; c++) begin
         #4 chk($sformatf("ws3 wr wait%0d hready", c), {31'b0, ready3}, 32'd0);
         tick;
      end
      #4 chk("ws3 wr done hready", {31'b0, ready3}, 32'd1);
      chk("ws3 wr done hrdata", rdata3, 32'd0);
      tick;
      drive(0, 1, I, 0, 2, 0, 0);
      for (int c = 0; c < 3; c++) begin
         #4 chk($sformatf("ws3 rd wait%0d hready", c), {31'b0, ready3}, 32'd0);
         chk($sformatf("ws3 rd wait%0d hrdata", c), rdata3, 32'd0);
         tick;
      end
      #4 chk("ws3 rd done hready", {31'b0, ready3}, 32'd1);
      chk("ws3 rd done hrdata", rdata3, 32'h5A5A1234);
      tick;
      #4 chk("ws3 after hrdata", rdata3, 32'd0);
      chk("ws3 hresp", {31'b0, resp3}, 32'd0);
      tick;
      // reset lands on the completion edge of a write: no commit
      drive(0, 1, N, 1, 2, 32'h20, 0);
      tick;
      drive(0, 1, I, 0, 2, 0, 32'hFFFFFFFF);
      for (int c = 0; c < 3; c++) begin
         #4 chk($sformatf("rst wait%0d hready", c), {31'b0, ready3}, 32'd0);
         tick;
      end
      hreset = 1'b1;
      tick;
      hreset = 1'b0;
      drive(0, 1, N, 0, 2, 32'h20, 0);
      #4 chk("rst hready", {31'b0, ready3}, 32'd1);
      chk("rst hresp", {31'b0, resp3}, 32'd0);
      chk("rst hrdata", rdata3, 32'd0);
      tick;
      drive(0, 1, I, 0, 2, 0, 0);
      for (int c = 0; c < 3; c++) begin
         #4 chk($sformatf("rst rd wait%0d hready", c), {31'b0, ready3}, 32'd0);
         tick;
      end
      #4 chk("rst word kept", rdata3, 32'h5A5A1234);
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
